// File: rtl/btb_update_queue_if.sv
// rtl/btb_update_queue_if.sv - execute-side enqueue and BTB-side write bundle for btb_update_queue
//
// Purpose: groups every non-clock/reset signal of btb_update_queue.
// Signals:
//   ex_valid, ex_taken, ex_pc, ex_target  resolved branch from the execute stage
//   ex_ready                              queue can take a non-coalescing enqueue
//   btb_busy                              BTB cannot take a write this cycle
//   w_pc, target_in, load                 head entry and write strobe to the BTB
//   count                                 occupancy
// Modports: slave = the queue, master = the surrounding pipeline/BTB side.
interface btb_update_queue_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ex_valid;
    logic          ex_taken;
    logic [AW-1:0] ex_pc;
    logic [AW-1:0] ex_target;
    logic          ex_ready;
    logic          btb_busy;
    logic [AW-1:0] w_pc;
    logic [AW-1:0] target_in;
    logic          load;
    logic [CW-1:0] count;

    modport slave (
        input  ex_valid, ex_taken, ex_pc, ex_target, btb_busy,
        output ex_ready, w_pc, target_in, load, count
    );

    modport master (
        output ex_valid, ex_taken, ex_pc, ex_target, btb_busy,
        input  ex_ready, w_pc, target_in, load, count
    );
endinterface

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - coalescing FIFO between branch resolution and the BTB write port
//
// Purpose: buffers resolved taken branches and drains one per cycle into the
// BTB write port. A new update whose PC matches the most recently queued entry
// overwrites that entry's target instead of taking a new slot.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears pointers, count and storage
//   bus    btb_update_queue_if.slave (execute-side enqueue, BTB-side write, count)
module btb_update_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    btb_update_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] pc_q  [DEPTH];
    logic [AW-1:0] pc_d  [DEPTH];
    logic [AW-1:0] tgt_q [DEPTH];
    logic [AW-1:0] tgt_d [DEPTH];

    logic          empty;
    logic          load;
    logic          req;
    logic          coal;
    logic          ready;
    logic          enq;
    logic [PW-1:0] last_idx;

    always_comb begin
        empty    = (count_q == '0);
        load     = !empty && !bus.btb_busy;
        req      = bus.ex_valid && bus.ex_taken;
        last_idx = tail_q - PW'(1);
        // Merging into the only entry while it is leaving would lose the new
        // target, so that case falls through to a normal enqueue.
        coal     = req && !empty && (bus.ex_pc == pc_q[last_idx])
                   && !((count_q == CW'(1)) && load);
        // A dequeue frees the head slot this edge, so a full queue still
        // accepts: the write lands in the slot being vacated.
        ready    = (count_q < CW'(DEPTH)) || load;
        enq      = req && !coal && ready;

        head_d = head_q;
        tail_d = tail_q;
        pc_d   = pc_q;
        tgt_d  = tgt_q;

        if (coal) begin
            tgt_d[last_idx] = bus.ex_target;
        end
        if (enq) begin
            pc_d[tail_q]  = bus.ex_pc;
            tgt_d[tail_q] = bus.ex_target;
            tail_d        = tail_q + PW'(1);
        end
        if (load) begin
            head_d = head_q + PW'(1);
        end

        count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, load};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.load      = load;
    assign bus.w_pc      = empty ? '0 : pc_q[head_q];
    assign bus.target_in = empty ? '0 : tgt_q[head_q];
    assign bus.count     = count_q;
    assign bus.ex_ready  = ready;
endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - self-checking bench for btb_update_queue
module tb_btb_update_queue;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ent_t mq[$];

    btb_update_queue_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    btb_update_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model at
    // mid-cycle, then advance the model by the queue's rules at the edge.
    task automatic step(input logic v, input logic t, input logic [AW-1:0] pc,
                        input logic [AW-1:0] tgt, input logic busy);
        logic exp_load;
        logic exp_ready;
        logic req;
        logic coal;
        bus.ex_valid  = v;
        bus.ex_taken  = t;
        bus.ex_pc     = pc;
        bus.ex_target = tgt;
        bus.btb_busy  = busy;
        @(negedge clk);
        exp_load  = (mq.size() != 0) && !busy;
        exp_ready = (mq.size() < DEPTH) || exp_load;
        chk("load", 64'(bus.load), 64'(exp_load));
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("ex_ready", 64'(bus.ex_ready), 64'(exp_ready));
        chk("w_pc", 64'(bus.w_pc), (mq.size() != 0) ? 64'(mq[0].pc) : 64'd0);
        chk("target_in", 64'(bus.target_in), (mq.size() != 0) ? 64'(mq[0].tgt) : 64'd0);
        @(posedge clk);
        req  = v && t;
        coal = req && (mq.size() != 0) && (mq[$].pc == pc)
               && !((mq.size() == 1) && exp_load);
        if (coal) mq[$].tgt = tgt;
        if (exp_load) void'(mq.pop_front());
        if (req && !coal && exp_ready) mq.push_back('{pc: pc, tgt: tgt});
        #1;
    endtask

    task automatic idle(input logic busy);
        step(1'b0, 1'b0, '0, '0, busy);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.ex_taken  = 1'b0;
        bus.ex_pc     = '0;
        bus.ex_target = '0;
        bus.btb_busy  = 1'b0;
        #2;
        chk("rst_load", 64'(bus.load), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.ex_ready), 64'd1);
        chk("rst_w_pc", 64'(bus.w_pc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single enqueue then drain
        step(1, 1, 32'h0000002D, 32'hDEADBEEF, 0);
        chk("t1_count", 64'(bus.count), 64'd1);
        chk("t1_w_pc", 64'(bus.w_pc), 64'h2D);
        chk("t1_tgt", 64'(bus.target_in), 64'hDEADBEEF);
        idle(0);
        chk("t1_drained", 64'(bus.count), 64'd0);

        // Fill while busy, drop a 5th, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 1, AW'(i * 16), AW'(32'h100 + i), 1);
        chk("t2_full", 64'(bus.count), 64'd4);
        chk("t2_ready", 64'(bus.ex_ready), 64'd0);
        step(1, 1, 32'h50, 32'h150, 1);
        chk("t2_drop", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) idle(0);
        chk("t2_empty", 64'(bus.count), 64'd0);

        // Coalesce behind a busy BTB
        step(1, 1, 32'h1000002D, 32'hFEEBFEEB, 1);
        step(1, 1, 32'h1000002D, 32'h00BADBAD, 1);
        chk("t3_count", 64'(bus.count), 64'd1);
        chk("t3_tgt", 64'(bus.target_in), 64'h00BADBAD);
        idle(0);
        idle(0);

        // Full queue with simultaneous dequeue and enqueue
        for (int i = 0; i < 4; i++) step(1, 1, AW'(32'hA0 + i * 16), AW'(i), 1);
        step(1, 1, 32'h60, 32'h600, 0);
        chk("t4_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < 5; i++) idle(0);

        // Not-taken ignored; coalesce exclusion while the only entry drains
        step(1, 0, 32'h70, 32'h700, 0);
        chk("t5_nt", 64'(bus.count), 64'd0);
        step(1, 1, 32'h80, 32'h1, 0);
        step(1, 1, 32'h80, 32'h1234, 0);
        chk("t5_count", 64'(bus.count), 64'd1);
        chk("t5_w_pc", 64'(bus.w_pc), 64'h80);
        chk("t5_tgt", 64'(bus.target_in), 64'h1234);
        idle(0);

        // Asynchronous reset mid-cycle with entries queued
        for (int i = 0; i < 3; i++) step(1, 1, AW'(32'hC00 + i * 4), AW'(i + 7), 1);
        #3 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("t6_load", 64'(bus.load), 64'd0);
        chk("t6_count", 64'(bus.count), 64'd0);
        chk("t6_w_pc", 64'(bus.w_pc), 64'd0);
        chk("t6_tgt", 64'(bus.target_in), 64'd0);
        chk("t6_ready", 64'(bus.ex_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 1, 32'hD00, 32'hD0D0, 0);
        idle(0);
        idle(0);

        // Randomized traffic with a small PC pool to exercise coalescing
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                 AW'(32'h4000 + 4 * $urandom_range(0, 2)), AW'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end
        for (int n = 0; n < 6; n++) idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Buffers resolved taken branches from the execute stage and drains them, one per cycle, into the BTB write port (w_pc, target_in, load).
- Decouples execute-stage resolution timing from BTB write availability.
- Coalesces back-to-back updates to the same branch PC.
- Sits directly upstream of btb; its outputs connect 1:1 to btb's w_pc, target_in and load.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- AW, 32, PC/target width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  resolved branch presented this cycle.
- ex_taken  in  1  resolved branch was taken.
- ex_pc  in  AW  PC of the resolved branch.
- ex_target  in  AW  resolved target address.
- ex_ready  out  1  queue can accept a non-coalescing enqueue this cycle.
- btb_busy  in  1  BTB cannot accept a write this cycle; hold the head entry.
- w_pc  out  AW  head entry PC to the BTB.
- target_in  out  AW  head entry target to the BTB.
- load  out  1  BTB write strobe for the head entry.
- count  out  $clog2(DEPTH)+1  valid entries held.

Behaviour:
- Reset (rst_n low, asynchronous): head, tail and count clear to 0; all entry pc/target registers clear to 0. Outputs are load=0, w_pc=0, target_in=0, count=0, ex_ready=1. Reset mid-operation discards all queued entries.
- Storage: circular buffer with head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count tracks occupancy and distinguishes full from empty.
- Dequeue (deq):
  - load = (count != 0) && !btb_busy, combinational from registered state and btb_busy.
  - w_pc and target_in always show the head entry, or 0 when empty.
  - When load=1, head advances at the clock edge.
- Enqueue request (req) = ex_valid && ex_taken. Not-taken or invalid inputs are ignored and change no state.
- Coalesce hit (coal):
  - Condition: req, count != 0, ex_pc equals the tail-1 entry's PC, and that entry is not being dequeued this cycle, i.e. NOT (count==1 && load).
  - Effect: that entry's target is overwritten with ex_target. count and tail are unchanged.
  - Coalescing is allowed even when full.
- ex_ready = (count < DEPTH) || load.
- Normal enqueue: when req && !coal && ex_ready, write {ex_pc, ex_target} at tail and advance tail.
- Dropped input: req && !coal && !ex_ready. Upstream must hold or stall; the input is not stored.
- count next value = count + enq − deq. Simultaneous enqueue and dequeue leaves count unchanged, including when full, where it acts as a pass-through slot reuse.
- Latency: an entry enqueued at edge N is visible on w_pc/target_in in cycle N+1 at the earliest (empty queue). There is no same-cycle bypass.
- Ordering: strict FIFO; coalescing never reorders entries.
- btb_busy held high: head is stable and load=0. The queue fills, ex_ready falls at count==DEPTH, and w_pc/target_in remain unchanged.

Test Plan:
1. Reset, then enqueue pc=0x0000002D, tgt=0xDEADBEEF with btb_busy=0.
   - Next cycle: load=1, w_pc=0x0000002D, target_in=0xDEADBEEF, count=1.
   - Following cycle: count=0, load=0.
2. btb_busy=1; enqueue pc 0x10, 0x20, 0x30, 0x40 on consecutive cycles.
   - count reaches 4 and ex_ready=0.
   - A 5th enqueue pc=0x50 is dropped.
   - Release btb_busy: load=1 for 4 consecutive cycles, w_pc=0x10, 0x20, 0x30, 0x40 in order; count returns to 0.
3. btb_busy=1; enqueue pc=0x1000002D tgt=0xFEEBFEEB, then the same pc with tgt=0x00BADBAD.
   - count stays 1.
   - On release, a single write: w_pc=0x1000002D, target_in=0x00BADBAD.
4. Full queue with btb_busy=0; enqueue pc=0x60 in the same cycle.
   - ex_ready=1 and count stays 4.
   - The 0x60 entry appears last; tail and head wrap correctly through index 0.
5. Enqueue with ex_taken=0 (pc=0x70): count unchanged and load stays 0.
   - Coalesce exclusion case: count==1, head pc=0x80 draining this cycle, new pc=0x80 tgt=0x1234. Result: a new entry is enqueued, count remains 1, next cycle w_pc=0x80, target_in=0x1234.
6. With 3 entries queued, pulse rst_n low mid-cycle (asynchronous).
   - Immediately: load=0, count=0, w_pc=0, target_in=0, ex_ready=1.
   - After release, the first new enqueue drains correctly.
